pcileech_msix_tlp_tx: RTL
=========================

Name: pcileech_msix_tlp_tx

Overview:
- Consumes single-cycle MSI-X interrupt requests (valid/addr/data pulse) from the VMD MSI-X BAR block.
- Buffers the requests in a small FIFO and serialises each one into a posted Memory Write TLP (1 DW payload) on the 64-bit PCIe core TX AXI-stream.
- Sits between the BAR implementation and the TX arbiter of the TLP engine.

Parameters:
- FIFO_DEPTH, 4, request FIFO entries; power of 2, minimum 2.
- STAT_W, 16, width of the saturating statistics counters.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- msix_interrupt_valid  in  1  one-cycle request strobe; the source has no backpressure
- msix_interrupt_addr  in  64  MSI-X message address
- msix_interrupt_data  in  32  MSI-X message data
- cfg_requester_id  in  16  {bus,dev,fn} of this function
- cfg_bus_master_en  in  1  Command register BME
- tx_tdata  out  64  TLP beat; DW0 in [31:0], DW1 in [63:32]
- tx_tkeep  out  8  byte enables of the beat
- tx_tlast  out  1  last beat of the TLP
- tx_tvalid  out  1  beat valid
- tx_tready  in  1  core accepts the beat
- stat_overflow  out  STAT_W  requests dropped because the FIFO was full; saturates
- stat_misaligned  out  STAT_W  requests dropped because addr[1:0]!=0; saturates
- busy  out  1  FIFO not empty, or the FSM is not in IDLE

Behaviour:
- Reset: all outputs are 0, the FIFO is empty, the FSM is in IDLE, and the tag counter is 0.
- Reset mid-TLP: tx_tvalid drops in the following cycle and the partial TLP is abandoned (the core is reset in the same domain).

Push:
- On msix_interrupt_valid with addr[1:0]!=0: no push; stat_misaligned increments.
- Otherwise, if the FIFO is not full or a pop occurs in the same cycle: push {addr,data}.
- Otherwise: drop; stat_overflow increments.

Pop:
- Condition: FSM in IDLE, FIFO not empty, and cfg_bus_master_en=1.
- The entry loads into holding registers and the FSM moves to BEAT0.
- Latency: with BME=1 and the FSM idle, a push in cycle N gives tx_tvalid=1 in cycle N+2.
- BME=0: requests remain queued; pushing continues until the FIFO is full.
- BME deasserted mid-TLP: the TLP still completes.

TLP format:
- Fields: fmt/type MWr, TC=0, attr=0, length=1, first BE=4'hF, last BE=4'h0, tag=tag counter.
- 3DW form when addr[63:32]==0:
  - DW0=32'h4000_0001.
  - DW1={req_id,tag,4'h0,4'hF}.
  - DW2={addr[31:2],2'b00}.
  - DW3=data.
- 4DW form otherwise:
  - DW0=32'h6000_0001.
  - DW1 as in the 3DW form.
  - DW2=addr[63:32].
  - DW3={addr[31:2],2'b00}.
  - DW4=data.
- Data is sent without byte swap. req_id is sampled at pop.

FSM (IDLE, BEAT0, BEAT1, BEAT2):
- BEAT0: tdata={DW1,DW0}, tkeep=8'hFF, tlast=0. On tready go to BEAT1.
- BEAT1, 3DW: tdata={DW3,DW2}, tkeep=8'hFF, tlast=1. On tready go to IDLE and increment the tag.
- BEAT1, 4DW: tdata={DW3,DW2}, tkeep=8'hFF, tlast=0. On tready go to BEAT2.
- BEAT2, 4DW only: tdata={32'h0,DW4}, tkeep=8'h0F, tlast=1. On tready go to IDLE and increment the tag.
- AXI rule: while tvalid=1 and tready=0, tdata/tkeep/tlast are held stable. tvalid is never withdrawn except on rst.
- No return-to-IDLE bubble is required. IDLE lasts one cycle between TLPs, so the pop for the next TLP happens in that IDLE cycle.

Wrap-around:
- The tag counter wraps 8'hFF->8'h00.
- FIFO pointers wrap modulo FIFO_DEPTH.
- Statistics counters hold at all-ones.

Test Plan:
- 3DW TLP: BME=1, tready=1, push addr=64'h0000_0000_FEE0_0000, data=32'h0000_4021, req_id=16'h0300.
  - Beat0=64'h0300_000F_4000_0001.
  - Beat1=64'h0000_4021_FEE0_0000, tlast=1, tkeep=FF, first tvalid at N+2.
- 4DW TLP: push addr=64'h0000_0001_2345_6780, data=32'hDEAD_BEEF.
  - Beats: {DW1,32'h6000_0001}, then 64'h2345_6780_0000_0001, then 64'h0000_0000_DEAD_BEEF with tkeep=0F, tlast=1.
  - The tag is 1 greater than in the previous TLP.
- Backpressure: tready toggles 0/1 randomly over 3DW and 4DW TLPs → tdata/tkeep/tlast stay stable while stalled; exactly 2 or 3 beats are accepted per TLP.
- BME gating and overflow: BME=0, push 6 requests with FIFO_DEPTH=4 → stat_overflow=2, no tvalid. Then set BME=1 → 4 TLPs in push order.
- Misaligned and simultaneous traffic: push addr=...0002 → stat_misaligned=1, no TLP. Push into a full FIFO in the same cycle as a pop → accepted, stat_overflow unchanged.
- Reset mid-TLP: assert rst during BEAT1 of a 4DW TLP → tvalid=0 and stats=0 in the next cycle; a new push then yields a correct TLP with tag=0.

Source files
------------

// File: rtl/pcileech_msix_tlp_tx.sv
// -----------------------------------------------------------------------------
// pcileech_msix_tlp_tx
//
// Turns single-cycle MSI-X interrupt requests from the VMD MSI-X BAR block into
// posted Memory Write TLPs with a 1 DW payload. The TLPs go out on the 64-bit
// PCIe core TX AXI-stream toward the TLP engine's TX arbiter. A small FIFO
// absorbs bursts, because the request source has no backpressure.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   msix_interrupt_*       request strobe with 64-bit address and 32-bit data
//   cfg_requester_id       {bus,dev,fn}, sampled when a request is popped
//   cfg_bus_master_en      gates popping; a TLP already started still completes
//   tx_t*                  64-bit AXI-stream TX master (DW0 in [31:0])
//   stat_overflow          saturating count of requests dropped on a full FIFO
//   stat_misaligned        saturating count of requests dropped for addr[1:0]!=0
//   busy                   FIFO holds entries or a TLP is in flight
// -----------------------------------------------------------------------------
module pcileech_msix_tlp_tx #(
  parameter int FIFO_DEPTH = 4,
  parameter int STAT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              msix_interrupt_valid,
  input  logic [63:0]       msix_interrupt_addr,
  input  logic [31:0]       msix_interrupt_data,
  input  logic [15:0]       cfg_requester_id,
  input  logic              cfg_bus_master_en,
  output logic [63:0]       tx_tdata,
  output logic [7:0]        tx_tkeep,
  output logic              tx_tlast,
  output logic              tx_tvalid,
  input  logic              tx_tready,
  output logic [STAT_W-1:0] stat_overflow,
  output logic [STAT_W-1:0] stat_misaligned,
  output logic              busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_BEAT0, S_BEAT1, S_BEAT2} state_e;

  // The address is stored without bits [1:0]; misaligned requests never enter.
  typedef struct packed {
    logic [61:0] addr_w;  // addr[63:2]
    logic [31:0] data;
  } req_t;

  req_t fifo_mem [FIFO_DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  state_e            state_q, state_d;
  logic [31:0]       addr_hi_q, addr_hi_d;
  logic [29:0]       addr_lo_q, addr_lo_d;
  logic [31:0]       data_q, data_d;
  logic [7:0]        tag_q, tag_d;
  logic [63:0]       tdata_q, tdata_d;
  logic [7:0]        tkeep_q, tkeep_d;
  logic              tlast_q, tlast_d;
  logic              tvalid_q, tvalid_d;
  logic [STAT_W-1:0] stat_overflow_q, stat_overflow_d;
  logic [STAT_W-1:0] stat_misaligned_q, stat_misaligned_d;

  req_t        head;
  logic        fifo_empty, fifo_full;
  logic        req_aligned, pop, push;
  logic        head_4dw;
  logic [31:0] head_dw0;
  logic [63:0] second_beat;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned;
    // otherwise synthesis infers latches.
    head        = fifo_mem[rd_ptr_q];
    fifo_empty  = (count_q == '0);
    fifo_full   = (count_q == CNT_W'(FIFO_DEPTH));
    req_aligned = (msix_interrupt_addr[1:0] == 2'b00);
    pop         = (state_q == S_IDLE) && !fifo_empty && cfg_bus_master_en;
    // A full FIFO still accepts when the head leaves in the same cycle.
    push        = msix_interrupt_valid && req_aligned && (!fifo_full || pop);
    head_4dw    = (head.addr_w[61:30] != 32'h0);
    head_dw0    = head_4dw ? 32'h6000_0001 : 32'h4000_0001;
    // Second beat: 4DW carries {addr_lo, addr_hi}; 3DW carries {data, addr_lo}.
    second_beat = (addr_hi_q != 32'h0) ? {addr_lo_q, 2'b00, addr_hi_q}
                                       : {data_q, addr_lo_q, 2'b00};

    wr_ptr_d          = wr_ptr_q;
    rd_ptr_d          = rd_ptr_q;
    count_d           = count_q;
    state_d           = state_q;
    addr_hi_d         = addr_hi_q;
    addr_lo_d         = addr_lo_q;
    data_d            = data_q;
    tag_d             = tag_q;
    tdata_d           = tdata_q;
    tkeep_d           = tkeep_q;
    tlast_d           = tlast_q;
    tvalid_d          = tvalid_q;
    stat_overflow_d   = stat_overflow_q;
    stat_misaligned_d = stat_misaligned_q;

    if (msix_interrupt_valid && !req_aligned && (stat_misaligned_q != '1))
      stat_misaligned_d = stat_misaligned_q + STAT_W'(1);
    if (msix_interrupt_valid && req_aligned && fifo_full && !pop &&
        (stat_overflow_q != '1))
      stat_overflow_d = stat_overflow_q + STAT_W'(1);

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // Output beats are registered; each next beat is prepared on acceptance
    // of the current one, so data/keep/last hold while tready is low.
    unique case (state_q)
      S_IDLE: begin
        if (pop) begin
          addr_hi_d = head.addr_w[61:30];
          addr_lo_d = head.addr_w[29:0];
          data_d    = head.data;
          tdata_d   = {cfg_requester_id, tag_q, 4'h0, 4'hF, head_dw0};
          tkeep_d   = 8'hFF;
          tlast_d   = 1'b0;
          tvalid_d  = 1'b1;
          state_d   = S_BEAT0;
        end
      end
      S_BEAT0: begin
        if (tx_tready) begin
          tdata_d = second_beat;
          tkeep_d = 8'hFF;
          tlast_d = (addr_hi_q == 32'h0);
          state_d = S_BEAT1;
        end
      end
      S_BEAT1: begin
        if (tx_tready) begin
          if (addr_hi_q != 32'h0) begin
            tdata_d = {32'h0, data_q};
            tkeep_d = 8'h0F;
            tlast_d = 1'b1;
            state_d = S_BEAT2;
          end else begin
            tdata_d  = '0;
            tkeep_d  = '0;
            tlast_d  = 1'b0;
            tvalid_d = 1'b0;
            tag_d    = tag_q + 8'd1;
            state_d  = S_IDLE;
          end
        end
      end
      S_BEAT2: begin
        if (tx_tready) begin
          tdata_d  = '0;
          tkeep_d  = '0;
          tlast_d  = 1'b0;
          tvalid_d = 1'b0;
          tag_d    = tag_q + 8'd1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q          <= '0;
      rd_ptr_q          <= '0;
      count_q           <= '0;
      state_q           <= S_IDLE;
      addr_hi_q         <= '0;
      addr_lo_q         <= '0;
      data_q            <= '0;
      tag_q             <= '0;
      tdata_q           <= '0;
      tkeep_q           <= '0;
      tlast_q           <= 1'b0;
      tvalid_q          <= 1'b0;
      stat_overflow_q   <= '0;
      stat_misaligned_q <= '0;
    end else begin
      wr_ptr_q          <= wr_ptr_d;
      rd_ptr_q          <= rd_ptr_d;
      count_q           <= count_d;
      state_q           <= state_d;
      addr_hi_q         <= addr_hi_d;
      addr_lo_q         <= addr_lo_d;
      data_q            <= data_d;
      tag_q             <= tag_d;
      tdata_q           <= tdata_d;
      tkeep_q           <= tkeep_d;
      tlast_q           <= tlast_d;
      tvalid_q          <= tvalid_d;
      stat_overflow_q   <= stat_overflow_d;
      stat_misaligned_q <= stat_misaligned_d;
    end
  end

  // NOTE: the storage array has no reset; the pointers and count define which
  // entries are valid, so contents after reset are never observed.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= '{addr_w: msix_interrupt_addr[63:2],
                                      data:   msix_interrupt_data};
  end

  assign tx_tdata        = tdata_q;
  assign tx_tkeep        = tkeep_q;
  assign tx_tlast        = tlast_q;
  assign tx_tvalid       = tvalid_q;
  assign stat_overflow   = stat_overflow_q;
  assign stat_misaligned = stat_misaligned_q;
  assign busy            = (count_q != '0) || (state_q != S_IDLE);

endmodule
